// File: rtl/sprite_mem_writer_if.sv
// ----------------------------------------------------------------------------
// sprite_mem_writer_if
// Bus bundle for the sprite memory writer.
//   Write-request side : wr_valid, wr_ready, wr_element, wr_address, wr_data
//   Memory write port  : mem_we, mem_element, mem_address, mem_data
// Modports:
//   master : request producer / memory consumer (drives wr_*, observes mem_*)
//   slave  : the writer itself (accepts wr_*, drives wr_ready and mem_*)
// ----------------------------------------------------------------------------
interface sprite_mem_writer_if #(
    parameter int ELEMENTS = 3,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 12
);
    logic                wr_valid;
    logic                wr_ready;
    logic [ELEMENTS-1:0] wr_element;
    logic [ADDR_W-1:0]   wr_address;
    logic [DATA_W-1:0]   wr_data;

    logic                mem_we;
    logic [ELEMENTS-1:0] mem_element;
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_data;

    modport master (
        output wr_valid,
        output wr_element,
        output wr_address,
        output wr_data,
        input  wr_ready,
        input  mem_we,
        input  mem_element,
        input  mem_address,
        input  mem_data
    );

    modport slave (
        input  wr_valid,
        input  wr_element,
        input  wr_address,
        input  wr_data,
        output wr_ready,
        output mem_we,
        output mem_element,
        output mem_address,
        output mem_data
    );
endinterface

// File: rtl/sprite_mem_writer.sv
// ----------------------------------------------------------------------------
// sprite_mem_writer
// Buffers pixel writes for sprite memory and commits them only while the
// display is blanked (blank high). Optionally fills an entire sprite with a
// single colour.
//
// Optional feature macro: SPRITE_FILL_EN (whole-sprite fill engine; FILL state,
// fill counter and fill latches exist only when it is defined).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   blank        in   high = display not reading sprite memory
//   bus          slave modport of sprite_mem_writer_if (wr_* request bus and
//                mem_* sprite memory write port, all mem_* registered)
//   fill_start   in   one-cycle fill request (ignored without SPRITE_FILL_EN)
//   fill_element in   sprite to fill
//   fill_data    in   fill colour
//   fill_busy    out  fill in progress
//   pending      out  number of buffered write entries
// ----------------------------------------------------------------------------
module sprite_mem_writer #(
    parameter int ELEMENTS = 3,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     blank,
    sprite_mem_writer_if.slave       bus,
    input  logic                     fill_start,
    input  logic [ELEMENTS-1:0]      fill_element,
    input  logic [DATA_W-1:0]        fill_data,
    output logic                     fill_busy,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ELEMENTS + ADDR_W + DATA_W;

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

`ifdef SPRITE_FILL_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } state_t;

    // The fill counter has one spare bit so "all addresses written" is a
    // distinct value from the last address itself.
    localparam logic [ADDR_W:0] FILL_ZERO = (ADDR_W + 1)'(1'b0);
    localparam logic [ADDR_W:0] FILL_ONE  = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W:0] FILL_END  = {1'b1, {ADDR_W{1'b0}}};
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1
    } state_t;
`endif

    // Advance a FIFO pointer, wrapping at DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    state_t              state_r;
    state_t              state_s;

    logic [ENTRY_W-1:0]  fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_s;
    logic                last_push_r;

    logic                push_s;
    logic                pop_s;
    logic                wr_ready_s;
    logic                fill_busy_s;
    logic                fill_go_s;
    logic                fill_wr_s;

    logic                mem_we_r;
    logic [ELEMENTS-1:0] mem_element_r;
    logic [ADDR_W-1:0]   mem_address_r;
    logic [DATA_W-1:0]   mem_data_r;

`ifdef SPRITE_FILL_EN
    logic [ADDR_W:0]     fill_cnt_r;
    logic [ELEMENTS-1:0] fill_el_r;
    logic [DATA_W-1:0]   fill_data_r;

    // Fill engine status and per-cycle write strobe, all from registered state.
    always_comb begin
        fill_busy_s = (state_r == FILL);
        fill_wr_s   = (state_r == FILL) && blank && (fill_cnt_r != FILL_END);
    end
`else
    logic unused_fill_s;

    // Fill engine absent: fill inputs are sunk, status tied inactive.
    always_comb begin
        fill_busy_s   = 1'b0;
        fill_wr_s     = 1'b0;
        unused_fill_s = ^{fill_start, fill_element, fill_data};
    end
`endif

    // Handshake, FIFO push/pop decisions and next occupancy.
    always_comb begin
        wr_ready_s = (count_r < CNT_FULL) && !fill_busy_s;
        push_s     = bus.wr_valid && wr_ready_s;
        // An entry pushed on the previous edge is not yet eligible, so a
        // write never reaches memory sooner than two edges after acceptance.
        pop_s      = (state_r == DRAIN) && blank && (count_r > CNT_W'(last_push_r));
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // FSM next-state logic and fill acceptance.
    always_comb begin
        state_s   = state_r;
        fill_go_s = 1'b0;
        case (state_r)
            IDLE: begin
                if ((count_r != CNT_ZERO) && blank) begin
                    state_s = DRAIN;
`ifdef SPRITE_FILL_EN
                end else if (fill_start && (count_r == CNT_ZERO)) begin
                    state_s   = FILL;
                    fill_go_s = 1'b1;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (!blank || (count_s == CNT_ZERO)) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
`ifdef SPRITE_FILL_EN
            FILL: begin
                // Stay one cycle past the final write so fill_busy covers it.
                if (fill_cnt_r == FILL_END) begin
                    state_s = IDLE;
                end else begin
                    state_s = FILL;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO pointers, occupancy and freshness flag of the newest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            last_push_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_s;
            last_push_r <= push_s;
        end
    end

    // FIFO storage; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {bus.wr_element, bus.wr_address, bus.wr_data};
        end
    end

`ifdef SPRITE_FILL_EN
    // Fill latches and address counter; the counter holds while blank is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt_r  <= FILL_ZERO;
            fill_el_r   <= {ELEMENTS{1'b0}};
            fill_data_r <= {DATA_W{1'b0}};
        end else if (fill_go_s) begin
            fill_cnt_r  <= FILL_ZERO;
            fill_el_r   <= fill_element;
            fill_data_r <= fill_data;
        end else if (fill_wr_s) begin
            fill_cnt_r  <= fill_cnt_r + FILL_ONE;
        end else begin
            fill_cnt_r  <= fill_cnt_r;
        end
    end
`endif

    // Registered sprite memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_r      <= 1'b0;
            mem_element_r <= {ELEMENTS{1'b0}};
            mem_address_r <= {ADDR_W{1'b0}};
            mem_data_r    <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            mem_we_r <= 1'b1;
            {mem_element_r, mem_address_r, mem_data_r} <= fifo_mem_r[rd_ptr_r];
`ifdef SPRITE_FILL_EN
        end else if (fill_wr_s) begin
            mem_we_r      <= 1'b1;
            mem_element_r <= fill_el_r;
            mem_address_r <= fill_cnt_r[ADDR_W-1:0];
            mem_data_r    <= fill_data_r;
`endif
        end else begin
            mem_we_r <= 1'b0;
        end
    end

    assign bus.wr_ready    = wr_ready_s;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_element = mem_element_r;
    assign bus.mem_address = mem_address_r;
    assign bus.mem_data    = mem_data_r;
    assign fill_busy       = fill_busy_s;
    assign pending         = count_r;

endmodule

// File: doc/sprite_mem_writer.md
SPRITE_MEM_WRITER -- requirements
Module: sprite_mem_writer

Interface
REQ-001 SHALL have parameter ELEMENTS, default 3, width of the sprite element select.
REQ-002 SHALL have parameter ADDR_W, default 10, width of the sprite pixel address.
REQ-003 SHALL have parameter DATA_W, default 12, width of one RGB pixel word.
REQ-004 SHALL have parameter DEPTH, default 4, write-buffer entries (power of two).
REQ-005 SHALL have port clk  input  1  system clock; rising edge only.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port blank  input  1  high = display not reading sprite memory; writes allowed.
REQ-008 SHALL have port wr_valid  input  1  write request present.
REQ-009 SHALL have port wr_ready  output  1  write request can be accepted.
REQ-010 SHALL have port wr_element  input  ELEMENTS  target sprite.
REQ-011 SHALL have port wr_address  input  ADDR_W  target pixel.
REQ-012 SHALL have port wr_data  input  DATA_W  pixel colour.
REQ-013 SHALL have port fill_start  input  1  one-cycle pulse requesting whole-sprite fill.
REQ-014 SHALL have port fill_element  input  ELEMENTS  sprite to fill.
REQ-015 SHALL have port fill_data  input  DATA_W  fill colour.
REQ-016 SHALL have port fill_busy  output  1  fill in progress.
REQ-017 SHALL have port pending  output  clog2(DEPTH)+1  buffered entry count.
REQ-018 SHALL have ports mem_we (1), mem_element (ELEMENTS), mem_address (ADDR_W), mem_data (DATA_W), all outputs, driving the sprite memory write port.

Function
REQ-019 SHALL accept a write on a rising edge where wr_valid and wr_ready are both high, storing {element,address,data} in a FIFO.
REQ-020 SHALL drive wr_ready = (pending < DEPTH) and not fill_busy, combinationally from registered state.
REQ-021 SHALL implement FSM states IDLE, DRAIN, FILL.
REQ-022 IDLE -> DRAIN when pending > 0 and blank high; IDLE -> FILL when fill_start high and pending = 0; fill_start SHALL be ignored in any other case or state.
REQ-023 In DRAIN, each cycle with blank high and pending > 0 SHALL pop one entry and register it onto mem_* with mem_we high for exactly one cycle.
REQ-024 DRAIN -> IDLE when blank low or pending reaches 0; unpopped entries SHALL be retained in order.
REQ-025 Latency: entry accepted at edge N with blank high SHALL appear with mem_we = 1 after edge N+2 at the earliest.
REQ-026 Simultaneous push and pop SHALL leave pending unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 In FILL, SHALL write fill_data to fill_element at addresses 0 .. 2^ADDR_W-1, ascending, one per cycle while blank high; counter SHALL hold and mem_we SHALL be low while blank low.
REQ-028 fill_element and fill_data SHALL be latched at fill_start acceptance; later changes ignored.
REQ-029 fill_busy SHALL be high from the cycle after fill_start acceptance until the cycle after the final address is written; FILL -> IDLE then.
REQ-030 All mem_* outputs SHALL be registered; mem_we SHALL never be high while blank was low at the preceding edge.

Reset
REQ-031 reset low SHALL immediately set FSM to IDLE, pending 0, FIFO pointers 0, fill counter 0, fill_busy 0, mem_we 0, mem_element/mem_address/mem_data 0.
REQ-032 Reset mid-DRAIN or mid-FILL SHALL discard all buffered entries and the fill without completing any further write.

Configuration
REQ-033 With macro SPRITE_FILL_EN defined, the FILL state, fill counter and REQ-027..029 SHALL be compiled in.
REQ-034 Without SPRITE_FILL_EN, fill_start, fill_element, fill_data SHALL be ignored, fill_busy SHALL be tied 0, FILL state SHALL not exist.

Verification
REQ-035 blank=1, write {el=2,addr=0x005,data=0xF0F} at edge 1 -> mem_we=1 with el=2, addr=0x005, data=0xF0F after edge 3; pending back to 0.
REQ-036 blank=0, push 4 entries -> pending=4, wr_ready=0, mem_we stays 0; raise blank -> 4 writes in push order on 4 consecutive cycles.
REQ-037 blank=1 then dropped after 2 pops of 4 entries -> mem_we 0 while blank low, pending=2; blank restored -> remaining 2 written in order.
REQ-038 SPRITE_FILL_EN, fill_start el=1 data=0x000, blank=1 -> 1024 writes addr 0..1023, fill_busy high 1025 cycles, wr_ready 0 throughout; toggling blank stretches fill with no skipped/duplicated address.
REQ-039 reset asserted with pending=3 mid-DRAIN -> all outputs 0 immediately, pending=0, no further mem_we after release.
REQ-040 Without SPRITE_FILL_EN, fill_start pulse -> fill_busy 0, no mem_we, wr_ready unaffected.
